// File: rtl/pixel_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// pixel_unpacker_pkg
// Shared video constants for the pixel unpacker slice: default pixel format,
// word packing, active frame geometry, and the widths of the pixel-in-word,
// column and row counters derived from that geometry.
// No ports; imported by pixel_unpacker and word_fifo2.
// ---------------------------------------------------------------------------
package pixel_unpacker_pkg;

    // RGB565 pixels, eight of them per 128-bit buffer word
    localparam int PIX_W_DEF        = 16;
    localparam int PIX_PER_WORD_DEF = 8;
    localparam int WORD_W_DEF       = PIX_W_DEF * PIX_PER_WORD_DEF;

    // 640x480 active area
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // Each exposure contributes one word, so one stored entry holds three
    localparam int EXPOSURES = 3;

    // Width of a counter that must hold 0..n-1; never narrower than one bit
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int K_W_DEF = cntWidth(PIX_PER_WORD_DEF);
    localparam int X_W_DEF = cntWidth(H_ACTIVE_DEF);
    localparam int Y_W_DEF = cntWidth(V_ACTIVE_DEF);

endpackage

// File: rtl/pixel_unpacker_word_fifo2.sv
// ---------------------------------------------------------------------------
// word_fifo2
// Two-entry FIFO holding complete word triples (high/mid/low exposure
// concatenated). The caller only pushes when there is room (or when the
// head is popped in the same cycle) and only pops when non-empty.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, empties the FIFO
//   push_i       write data_i this cycle
//   pop_i        retire the head entry this cycle
//   flush_i      empty the FIFO; a push in the same cycle lands after the flush
//   data_i       entry to write
//   head_o       oldest entry (meaningless when occupancy_o is 0)
//   occupancy_o  number of stored entries, 0..2
// ---------------------------------------------------------------------------
module word_fifo2
    import pixel_unpacker_pkg::*;
#(
    parameter int DATA_W = EXPOSURES * WORD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        occupancy_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rdPtr_q, rdPtr_d;
    logic              wrPtr_q, wrPtr_d;
    logic [1:0]        count_q, count_d;
    logic              writeEn;
    logic              writeIdx;

    // Pointer and occupancy update. A flush restarts both pointers at entry 0,
    // so a push arriving with the flush becomes the sole, head entry.
    always_comb begin
        rdPtr_d  = rdPtr_q;
        wrPtr_d  = wrPtr_q;
        count_d  = count_q;
        writeEn  = 1'b0;
        writeIdx = wrPtr_q;
        if (flush_i) begin
            rdPtr_d  = 1'b0;
            wrPtr_d  = 1'b0;
            count_d  = 2'd0;
            writeIdx = 1'b0;
            if (push_i) begin
                writeEn = 1'b1;
                wrPtr_d = 1'b1;
                count_d = 2'd1;
            end
        end else begin
            if (push_i) begin
                writeEn = 1'b1;
                wrPtr_d = ~wrPtr_q;
            end
            if (pop_i) begin
                rdPtr_d = ~rdPtr_q;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Control state; reset discards stored entries by zeroing occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while occupancy > 0.
    // When full with a simultaneous pop, the write slot equals the head being
    // retired, so overwriting it here is safe.
    always_ff @(posedge clk_i) begin
        if (writeEn) begin
            mem_q[writeIdx] <= data_i;
        end
    end

    assign head_o      = mem_q[rdPtr_q];
    assign occupancy_o = count_q;

endmodule

// File: rtl/pixel_unpacker.sv
// ---------------------------------------------------------------------------
// pixel_unpacker
// Buffers 128-bit word triples (high/mid/low exposure) in a two-entry FIFO
// and serialises them into one pixel triple per accepted transfer,
// least-significant pixel first, while tracking the x/y raster position.
// Ports:
//   clk_25M            pixel clock
//   rst_25M            synchronous active-high reset
//   pixel_data_high/mid/low  word of each exposure
//   pixel_data_valid   one-cycle qualifier per word triple (no backpressure)
//   frame_start        clears position and flushes stored words
//   out_ready          downstream accepts the current pixel triple
//   pix_high/mid/low   current pixel of each exposure (zero when idle)
//   pix_valid          pixel triple valid
//   pix_sol / pix_sof  current position is x==0 / x==0 and y==0
//   in_ready           word storage has room this cycle
//   overflow           sticky: a word triple was dropped
// ---------------------------------------------------------------------------
module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int PIX_W        = PIX_W_DEF,
    parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF
) (
    input  logic                          clk_25M,
    input  logic                          rst_25M,
    input  logic [PIX_W*PIX_PER_WORD-1:0] pixel_data_high,
    input  logic [PIX_W*PIX_PER_WORD-1:0] pixel_data_mid,
    input  logic [PIX_W*PIX_PER_WORD-1:0] pixel_data_low,
    input  logic                          pixel_data_valid,
    input  logic                          frame_start,
    input  logic                          out_ready,
    output logic [PIX_W-1:0]              pix_high,
    output logic [PIX_W-1:0]              pix_mid,
    output logic [PIX_W-1:0]              pix_low,
    output logic                          pix_valid,
    output logic                          pix_sol,
    output logic                          pix_sof,
    output logic                          in_ready,
    output logic                          overflow
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int K_W    = cntWidth(PIX_PER_WORD);
    localparam int X_W    = cntWidth(H_ACTIVE);
    localparam int Y_W    = cntWidth(V_ACTIVE);

    localparam logic [K_W-1:0] K_LAST = K_W'(PIX_PER_WORD - 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic [EXPOSURES*WORD_W-1:0] fifoHead;
    logic [1:0]                  occupancy;
    logic                        fifoPush;
    logic                        fifoPop;
    logic                        headValid;
    logic                        transfer;
    logic                        lastPix;
    logic [WORD_W-1:0]           wordHigh, wordMid, wordLow;

    logic [K_W-1:0] kCnt_q, kCnt_d;
    logic [X_W-1:0] xCnt_q, xCnt_d;
    logic [Y_W-1:0] yCnt_q, yCnt_d;
    logic           overflow_q, overflow_d;

    assign headValid = (occupancy != 2'd0);
    assign transfer  = headValid && out_ready;
    assign lastPix   = (kCnt_q == K_LAST);

    // A frame_start cancels the pop of a coincident transfer; the flush wins.
    // Pushes are accepted after a flush, into free space, or into the slot
    // freed by a pop in the same cycle.
    assign fifoPop  = transfer && lastPix && !frame_start;
    assign fifoPush = pixel_data_valid &&
                      (frame_start || (occupancy != 2'd2) || fifoPop);

    word_fifo2 #(
        .DATA_W (EXPOSURES * WORD_W)
    ) u_word_fifo2 (
        .clk_i       (clk_25M),
        .rst_i       (rst_25M),
        .push_i      (fifoPush),
        .pop_i       (fifoPop),
        .flush_i     (frame_start),
        .data_i      ({pixel_data_high, pixel_data_mid, pixel_data_low}),
        .head_o      (fifoHead),
        .occupancy_o (occupancy)
    );

    // Pixel index within the head word and raster position. A frame_start
    // overrides any coincident transfer so the next pixel starts a new frame.
    always_comb begin
        kCnt_d     = kCnt_q;
        xCnt_d     = xCnt_q;
        yCnt_d     = yCnt_q;
        overflow_d = overflow_q | (pixel_data_valid & ~fifoPush);
        if (frame_start) begin
            kCnt_d = '0;
            xCnt_d = '0;
            yCnt_d = '0;
        end else if (transfer) begin
            kCnt_d = lastPix ? '0 : kCnt_q + K_W'(1);
            if (xCnt_q == X_LAST) begin
                xCnt_d = '0;
                yCnt_d = (yCnt_q == Y_LAST) ? '0 : yCnt_q + Y_W'(1);
            end else begin
                xCnt_d = xCnt_q + X_W'(1);
            end
        end
    end

    // Counter and sticky-flag registers
    always_ff @(posedge clk_25M) begin
        if (rst_25M) begin
            kCnt_q     <= '0;
            xCnt_q     <= '0;
            yCnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            kCnt_q     <= kCnt_d;
            xCnt_q     <= xCnt_d;
            yCnt_q     <= yCnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Output selection; pixel outputs read as zero while nothing is stored so
    // stale FIFO contents never leak out after reset or a flush.
    assign wordLow  = fifoHead[WORD_W-1:0];
    assign wordMid  = fifoHead[2*WORD_W-1:WORD_W];
    assign wordHigh = fifoHead[3*WORD_W-1:2*WORD_W];

    assign pix_high  = headValid ? wordHigh[kCnt_q*PIX_W +: PIX_W] : '0;
    assign pix_mid   = headValid ? wordMid[kCnt_q*PIX_W +: PIX_W]  : '0;
    assign pix_low   = headValid ? wordLow[kCnt_q*PIX_W +: PIX_W]  : '0;
    assign pix_valid = headValid;
    assign pix_sol   = (xCnt_q == '0);
    assign pix_sof   = (xCnt_q == '0) && (yCnt_q == '0);
    assign in_ready  = (occupancy != 2'd2);
    assign overflow  = overflow_q;

endmodule

// File: doc/pixel_unpacker.md
PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 Parameter PIX_W, default 16, bits per pixel (RGB565).
REQ-002 Parameter PIX_PER_WORD, default 8, pixels per 128-bit word.
REQ-003 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-004 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-005 clk_25M  input  1  pixel clock; single clock domain for the whole block.
REQ-006 rst_25M  input  1  reset, synchronous, active-high.
REQ-007 pixel_data_high  input  128  high-exposure word from the pixel buffer.
REQ-008 pixel_data_mid  input  128  mid-exposure word.
REQ-009 pixel_data_low  input  128  low-exposure word.
REQ-010 pixel_data_valid  input  1  one-cycle qualifier per word triple; no backpressure exists upstream.
REQ-011 frame_start  input  1  one-cycle pulse marking the start of a new frame.
REQ-012 out_ready  input  1  downstream accepts the current pixel triple.
REQ-013 pix_high, pix_mid, pix_low  output  PIX_W each  current pixel of each exposure.
REQ-014 pix_valid  output  1  pixel triple valid.
REQ-015 pix_sol  output  1  current pixel is x==0; pix_sof  output  1  current pixel is x==0 and y==0.
REQ-016 in_ready  output  1  word storage can accept a triple this cycle.
REQ-017 overflow  output  1  sticky: a word triple was dropped.

Function
REQ-018 Word storage SHALL be a 2-entry FIFO, each entry holding all three 128-bit words.
REQ-019 Push SHALL occur on pixel_data_valid when occupancy <2, or when occupancy ==2 and a pop occurs the same cycle.
REQ-020 A pixel_data_valid that cannot push SHALL drop the triple and set overflow, which stays 1 until reset.
REQ-021 in_ready SHALL equal (occupancy <2); it is combinational from state only.
REQ-022 Pixel k (0..PIX_PER_WORD-1) of a word SHALL be bits [k*PIX_W +: PIX_W], least-significant pixel first, same k for all three exposures.
REQ-023 pix_valid SHALL be 1 whenever the FIFO is non-empty; pix_* SHALL present pixel k of the head entry.
REQ-024 Transfer = pix_valid && out_ready; each transfer advances k; transfer at k==PIX_PER_WORD-1 SHALL pop the head and reset k to 0.
REQ-025 While pix_valid && !out_ready, pix_*, pix_sol, pix_sof SHALL hold stable.
REQ-026 Latency: triple pushed into an empty FIFO at cycle N SHALL appear as pixel 0 with pix_valid=1 at cycle N+1; sustained throughput one pixel per cycle.
REQ-027 Counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) SHALL advance on each transfer; x wraps to 0 after H_ACTIVE-1 and increments y; y wraps to 0 after V_ACTIVE-1.
REQ-028 frame_start SHALL clear x, y, k and flush the FIFO; overflow is unaffected.
REQ-029 frame_start coincident with pixel_data_valid SHALL flush first, then push the new triple (it belongs to the new frame).
REQ-030 frame_start coincident with a transfer SHALL discard the transfer's counter/pop effects.

Reset
REQ-031 On rst_25M: occupancy 0, k=0, x=0, y=0, overflow=0, pix_valid=0, in_ready=1, pix_high/mid/low=0, pix_sol=1, pix_sof=1.
REQ-032 Reset asserted mid-word SHALL discard all stored words immediately on the next clock edge; reset has priority over frame_start and pixel_data_valid.

Structure
REQ-033 PIX_W, PIX_PER_WORD, H_ACTIVE, V_ACTIVE defaults and the counter widths SHALL live in the shared video package.
REQ-034 The 2-entry, 384-bit-wide storage SHALL be a sub-module named word_fifo2 with push, pop, flush, occupancy; unpacking and counters stay in pixel_unpacker.

Verification
REQ-035 Single word, out_ready=1: push triple with high word 0x0007_0006_..._0000 -> pix_high 0x0000..0x0007 on 8 consecutive cycles starting N+1, then pix_valid=0.
REQ-036 Backpressure: out_ready toggles 1,0,0,1 -> pixel 1 held for 3 cycles, no pixel skipped or duplicated.
REQ-037 Overflow: 3 pushes on consecutive cycles with out_ready=0 -> third dropped, overflow=1 from next cycle, in_ready=0 after second push.
REQ-038 Full-with-pop: occupancy 2, push on cycle the 8th pixel transfers -> push accepted, overflow stays 0.
REQ-039 Wrap: 80x480 words streamed -> pix_sol every 640 transfers, pix_sof after transfer 307200, x/y back to 0.
REQ-040 frame_start with pixel_data_valid mid-word, then reset mid-word -> new word's pixel 0 with pix_sof=1 next cycle; after reset all outputs per REQ-031.
